gray2rgb_stream: RTL and testbench
==================================

Name: gray2rgb_stream

Overview:
- Re-expands the 8-bit grayscale/edge-magnitude pixel stream from the Sobel path into 24-bit RGB for the VGA/display writer.
- Sits downstream of the edge detector; the inverse direction of the RGB-to-gray front end.
- Three display modes: plain gray replicate, threshold edge overlay, false-colour heat map.
- Two-stage pipeline with valid/ready flow control and SOF/EOL sideband passthrough.

Parameters:
- OVERLAY_RGB, 24'hFF0000, colour substituted for edge pixels in overlay mode.
- COUNT_W, 20, width of the edge-pixel counter (optional feature only).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- gray_in  in  8  input pixel.
- in_valid  in  1  input beat valid.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_eol  in  1  last pixel of line; qualified by in_valid.
- in_ready  out  1  block can accept a beat this cycle.
- mode_cfg  in  2  0=replicate, 1=overlay, 2=heat map, 3=reserved (behaves as 0).
- thresh_cfg  in  8  overlay/count threshold.
- rgb_out  out  24  R=[23:16], G=[15:8], B=[7:0].
- out_valid  out  1  output beat valid.
- out_sof  out  1  SOF aligned to rgb_out.
- out_eol  out  1  EOL aligned to rgb_out.
- out_ready  in  1  downstream accepts the beat.
- edge_count  out  COUNT_W  hit count of the previous frame; present only with the optional feature.

Behaviour:
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Pipeline enable: en = out_ready || !out_valid. in_ready = en.
- Global stall: all stages hold while en=0. Bubbles are not collapsed.
- Stage 1 on en:
  - s1_valid <= accept.
  - Capture gray, sof, eol.
  - Compute hit = (gray >= thresh_active).
- Stage 2 on en:
  - s2_valid <= s1_valid.
  - Compute RGB from the stage-1 values; drive outputs.
- Latency is exactly 2 cycles from accept to out_valid when out_ready is held high. Throughput is 1 pixel/cycle.
- Config latching:
  - mode_active and thresh_active load from mode_cfg and thresh_cfg only on an accepted beat with in_sof=1.
  - The new values apply to that SOF pixel onward.
  - Mid-frame changes to mode_cfg or thresh_cfg are ignored until the next SOF.
- Colour rules, with g = stage-1 gray and d = {g[6:0],1'b0}:
  - Mode 0/3: R=G=B=g.
  - Mode 1: hit ? OVERLAY_RGB : {g,g,g}.
  - Mode 2, g<128: R=0, G=d, B=~d.
  - Mode 2, g>=128: R=d, G=~d, B=0.
- Mode 2 boundary values:
  - g=0 gives 0000FF.
  - g=127 gives 00FE01.
  - g=128 gives 00FF00.
  - g=255 gives FE0100.
- Reset:
  - s1_valid=0, s2_valid=0 (so out_valid=0); rgb_out=0; out_sof=0; out_eol=0.
  - mode_active=0; thresh_active=8'hFF.
  - Counters=0.
- In-flight pixels are dropped on reset mid-frame. The first post-reset frame uses mode 0 until a SOF is accepted.
- Outputs hold stable while out_valid && !out_ready, per the valid/ready rules.
- SOF with EOL on the same beat (1-pixel line) is legal; both flags propagate.

Optional Feature:
- Macro: GRAY2RGB_EDGE_COUNT_EN.
- Defined:
  - A running counter increments on each stage-1 advance with s1_valid && hit. It saturates at all-ones.
  - When a SOF pixel advances into stage 2, edge_count <= running count. The running count then restarts at the SOF pixel's own hit (0 or 1).
  - edge_count resets to 0.
- Undefined: the edge_count port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sobel_pkg holds:
  - Mode encodings: MODE_GRAY=2'd0, MODE_OVERLAY=2'd1, MODE_HEAT=2'd2.
  - PIX_W=8 and RGB_W=24.
  - The RGB field bit positions.
- One natural sub-module: gray2rgb_map. It is the purely combinational mode/gray/hit to RGB mapping, instantiated in stage 2 and reusable by the bench as a reference model.

Test Plan:
- Mode 0, out_ready=1, stream 00,7F,FF with SOF on first -> rgb 000000, 7F7F7F, FFFFFF exactly 2 cycles after each accept.
- Mode 1, thresh 80, stream 7F,80,C3 -> 7F7F7F, FF0000, FF0000. Change mode_cfg to 0 mid-frame -> no effect until the next SOF.
- Mode 2, stream 00,7F,80,FF -> 0000FF, 00FE01, 00FF00, FE0100.
- Backpressure: out_ready low for 3 cycles mid-stream -> in_ready low, rgb_out/out_sof/out_eol held stable, no pixel lost or duplicated, order preserved.
- Reset asserted with 2 pixels in flight -> out_valid=0 next cycle, in-flight pixels never emitted, mode reverts to 0.
- With GRAY2RGB_EDGE_COUNT_EN, thresh 10, frame of 6 pixels with 4 >= 10, then next SOF -> edge_count=4 after the SOF advances to stage 2.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel display path: pixel/RGB widths,
// display-mode encodings and RGB field positions.
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int RGB_W = 24;

    // RGB field bit positions: R=[23:16], G=[15:8], B=[7:0].
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // Display modes; the reserved encoding renders like MODE_GRAY.
    typedef enum logic [1:0] {
        MODE_GRAY    = 2'd0,
        MODE_OVERLAY = 2'd1,
        MODE_HEAT    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Assemble one RGB word from its three channels.
    function automatic logic [RGB_W-1:0] pack_rgb(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        logic [RGB_W-1:0] rgb;
        rgb                = '0;
        rgb[R_MSB:R_LSB]   = r;
        rgb[G_MSB:G_LSB]   = g;
        rgb[B_MSB:B_LSB]   = b;
        return rgb;
    endfunction

endpackage

// File: rtl/gray2rgb_map.sv
// Purely combinational gray -> RGB colour mapping for the three display
// modes. Stateless, so it can sit in any pipeline stage.
module gray2rgb_map
    import sobel_pkg::*;
#(
    parameter logic [RGB_W-1:0] OVERLAY_RGB = 24'hFF0000
) (
    input  mode_e              mode_i,
    input  logic [PIX_W-1:0]   gray_i,
    input  logic               hit_i,
    output logic [RGB_W-1:0]   rgb_o
);

    logic [PIX_W-1:0] dbl;

    // Select the colour for the current pixel; replicate is the fallback.
    always_comb begin
        dbl   = {gray_i[PIX_W-2:0], 1'b0};
        rgb_o = pack_rgb(gray_i, gray_i, gray_i);
        case (mode_i)
            MODE_OVERLAY: begin
                if (hit_i) begin
                    rgb_o = OVERLAY_RGB;
                end
            end
            MODE_HEAT: begin
                // Lower half ramps blue->green, upper half green->red.
                if (gray_i[PIX_W-1]) begin
                    rgb_o = pack_rgb(dbl, ~dbl, '0);
                end else begin
                    rgb_o = pack_rgb('0, dbl, ~dbl);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/gray2rgb_stream.sv
// Two-stage gray -> RGB display stream with valid/ready flow control and
// SOF/EOL passthrough. Optional per-frame edge-pixel counter is built in
// when GRAY2RGB_EDGE_COUNT_EN is defined.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. out_valid never drops and rgb_out/out_sof/out_eol never change while
// out_valid && !out_ready. in_ready equals the global pipeline enable
// (out_ready || !out_valid); when it is low every stage holds, and bubbles
// are carried through the pipe rather than collapsed.
module gray2rgb_stream
    import sobel_pkg::*;
#(
    parameter logic [RGB_W-1:0] OVERLAY_RGB = 24'hFF0000
`ifdef GRAY2RGB_EDGE_COUNT_EN
    ,
    parameter int               COUNT_W     = 20
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PIX_W-1:0]   gray_in,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_eol,
    output logic               in_ready,
    input  logic [1:0]         mode_cfg,
    input  logic [PIX_W-1:0]   thresh_cfg,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eol,
    input  logic               out_ready
`ifdef GRAY2RGB_EDGE_COUNT_EN
    ,
    output logic [COUNT_W-1:0] edge_count
`endif
);

    // Global enable and input handshake.
    logic en;
    logic accept;
    logic sof_load;

    // Frame-latched configuration.
    mode_e            mode_active_q,   mode_active_d;
    logic [PIX_W-1:0] thresh_active_q, thresh_active_d;
    mode_e            mode_eff;
    logic [PIX_W-1:0] thresh_eff;

    // Stage 1 registers.
    logic             s1_valid_q;
    logic [PIX_W-1:0] s1_gray_q;
    logic             s1_sof_q;
    logic             s1_eol_q;
    logic             s1_hit_q;
    mode_e            s1_mode_q;

    // Stage 2 registers (drive the outputs directly).
    logic             s2_valid_q;
    logic [RGB_W-1:0] s2_rgb_q;
    logic             s2_sof_q;
    logic             s2_eol_q;

    logic [RGB_W-1:0] map_rgb;

    assign en       = out_ready || !s2_valid_q;
    assign accept   = in_valid && en;
    assign sof_load = accept && in_sof;
    assign in_ready = en;

    assign out_valid = s2_valid_q;
    assign rgb_out   = s2_rgb_q;
    assign out_sof   = s2_sof_q;
    assign out_eol   = s2_eol_q;

    // Config applies from the SOF pixel itself, so bypass the latch on that beat.
    always_comb begin
        mode_active_d   = mode_active_q;
        thresh_active_d = thresh_active_q;
        if (sof_load) begin
            mode_active_d   = mode_e'(mode_cfg);
            thresh_active_d = thresh_cfg;
        end
        mode_eff   = mode_active_d;
        thresh_eff = thresh_active_d;
    end

    // Frame-latched configuration registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_active_q   <= MODE_GRAY;
            thresh_active_q <= 8'hFF;
        end else begin
            mode_active_q   <= mode_active_d;
            thresh_active_q <= thresh_active_d;
        end
    end

    // Stage 1: capture pixel, sideband and threshold compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_gray_q  <= '0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_mode_q  <= MODE_GRAY;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_gray_q  <= gray_in;
            s1_sof_q   <= in_sof && in_valid;
            s1_eol_q   <= in_eol && in_valid;
            s1_hit_q   <= (gray_in >= thresh_eff);
            s1_mode_q  <= mode_eff;
        end
    end

    gray2rgb_map #(
        .OVERLAY_RGB (OVERLAY_RGB)
    ) u_map (
        .mode_i (s1_mode_q),
        .gray_i (s1_gray_q),
        .hit_i  (s1_hit_q),
        .rgb_o  (map_rgb)
    );

    // Stage 2: register the mapped colour and aligned sideband.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_rgb_q   <= '0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_rgb_q   <= map_rgb;
            s2_sof_q   <= s1_sof_q && s1_valid_q;
            s2_eol_q   <= s1_eol_q && s1_valid_q;
        end
    end

`ifdef GRAY2RGB_EDGE_COUNT_EN
    logic               s1_adv;
    logic [COUNT_W-1:0] run_q,  run_d;
    logic [COUNT_W-1:0] edge_q, edge_d;

    assign s1_adv     = en && s1_valid_q;
    assign edge_count = edge_q;

    // Running hit count; a SOF publishes the finished frame and restarts
    // the count at the SOF pixel's own hit.
    always_comb begin
        run_d  = run_q;
        edge_d = edge_q;
        if (s1_adv) begin
            if (s1_sof_q) begin
                edge_d = run_q;
                run_d  = COUNT_W'(s1_hit_q);
            end else if (s1_hit_q && !(&run_q)) begin
                run_d = run_q + COUNT_W'(1);
            end
        end
    end

    // Edge counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_q  <= '0;
            edge_q <= '0;
        end else begin
            run_q  <= run_d;
            edge_q <= edge_d;
        end
    end
`endif

endmodule

// File: tb/tb_gray2rgb_stream.sv
// Self-checking bench for gray2rgb_stream: directed steps in one initial
// block, a negedge monitor with an expected-result queue, and a final report.
module tb_gray2rgb_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  gray_in;
    logic        in_valid;
    logic        in_sof;
    logic        in_eol;
    logic        in_ready;
    logic [1:0]  mode_cfg;
    logic [7:0]  thresh_cfg;
    logic [23:0] rgb_out;
    logic        out_valid;
    logic        out_sof;
    logic        out_eol;
    logic        out_ready;
`ifdef GRAY2RGB_EDGE_COUNT_EN
    logic [19:0] edge_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: {sof, eol, rgb} per accepted beat plus its accept cycle.
    logic [25:0] exp_q[$];
    int          acc_q[$];

    // Bench-side model of the frame-latched configuration.
    logic [1:0]  m_mode = 2'd0;
    logic [7:0]  m_thr  = 8'hFF;
    bit          lat_chk = 1'b1;
    bit          held_v  = 1'b0;
    logic [25:0] held;

    gray2rgb_stream dut (
        .clock      (clock),
        .reset      (reset),
        .gray_in    (gray_in),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eol     (in_eol),
        .in_ready   (in_ready),
        .mode_cfg   (mode_cfg),
        .thresh_cfg (thresh_cfg),
        .rgb_out    (rgb_out),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_ready  (out_ready)
`ifdef GRAY2RGB_EDGE_COUNT_EN
        ,
        .edge_count (edge_count)
`endif
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference colour model written straight from the colour rules.
    function automatic logic [23:0] model(input logic [1:0] m, input logic [7:0] g,
                                          input logic [7:0] t);
        logic [7:0] d;
        d = {g[6:0], 1'b0};
        case (m)
            2'd1:    return (g >= t) ? 24'hFF0000 : {g, g, g};
            2'd2:    return (g < 8'd128) ? {8'h00, d, ~d} : {d, ~d, 8'h00};
            default: return {g, g, g};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: stall stability, output pops, input pushes.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            m_mode = 2'd0;
            m_thr  = 8'hFF;
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_sof, out_eol, rgb_out}), 32'(held));
            end
            held_v = 1'b0;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                held_v = 1'b1;
                held   = {out_sof, out_eol, rgb_out};
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_beat observed=%h expected=none",
                           {out_sof, out_eol, rgb_out});
                end
                if (exp_q.size() != 0) begin
                    logic [25:0] e;
                    int          a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("beat", 32'({out_sof, out_eol, rgb_out}), 32'(e));
                    if (lat_chk) chk("latency", 32'(cyc - a), 32'd2);
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_mode = mode_cfg;
                    m_thr  = thresh_cfg;
                end
                exp_q.push_back({in_sof, in_eol, model(m_mode, gray_in, m_thr)});
                acc_q.push_back(cyc);
            end
        end
    end

    // Driver: present one beat and hold it until accepted (bounded).
    task automatic send(input logic [7:0] g, input logic s, input logic e);
        int n;
        n        = 0;
        gray_in  = g;
        in_sof   = s;
        in_eol   = e;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        assert (n < 100) else begin
            failures++;
            $error("FAIL send_timeout observed=%0d expected=<100", n);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        gray_in    = '0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_eol     = 1'b0;
        mode_cfg   = 2'd0;
        thresh_cfg = 8'h00;
        out_ready  = 1'b1;

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_sof", 32'(out_sof), 32'd0);
        chk("rst_eol", 32'(out_eol), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef GRAY2RGB_EDGE_COUNT_EN
        chk("rst_edge_count", 32'(edge_count), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Mode 0 replicate.
        mode_cfg = 2'd0;
        send(8'h00, 1'b1, 1'b0);
        send(8'h7F, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        drain();

        // Mode 1 overlay, then a mid-frame config change that must be ignored.
        mode_cfg   = 2'd1;
        thresh_cfg = 8'h80;
        send(8'h7F, 1'b1, 1'b0);
        send(8'h80, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        mode_cfg   = 2'd0;
        thresh_cfg = 8'hFF;
        send(8'h40, 1'b0, 1'b0);
        send(8'h90, 1'b0, 1'b1);
        drain();
        // New SOF picks up mode 0; also a one-pixel line (SOF+EOL).
        send(8'h90, 1'b1, 1'b1);
        drain();

        // Mode 2 heat map boundaries.
        mode_cfg = 2'd2;
        send(8'h00, 1'b1, 1'b0);
        send(8'h7F, 1'b0, 1'b0);
        send(8'h80, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        drain();

        // Backpressure: out_ready low for 3 cycles mid-stream.
        mode_cfg = 2'd0;
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        drain();

        // Random frame with random mode/threshold and random backpressure.
        fork
            begin
                repeat (40) begin
                    @(posedge clock);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 16; i++) begin
            mode_cfg   = 2'($urandom_range(0, 3));
            thresh_cfg = 8'($urandom_range(0, 255));
            send(8'($urandom_range(0, 255)), (i == 0), (i == 15));
        end
        drain();
        repeat (45) @(posedge clock);
        #1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;

        // Reset with two pixels in flight; mode must revert to replicate.
        mode_cfg   = 2'd1;
        thresh_cfg = 8'h00;
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        mode_cfg = 2'd2;
        send(8'h80, 1'b0, 1'b1);
        drain();

`ifdef GRAY2RGB_EDGE_COUNT_EN
        // Edge counter: 4 of 6 pixels at or above 0x10.
        mode_cfg   = 2'd0;
        thresh_cfg = 8'h10;
        send(8'h20, 1'b1, 1'b0);
        send(8'h05, 1'b0, 1'b0);
        send(8'h10, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b1);
        send(8'h00, 1'b1, 1'b1);
        drain();
        chk("edge_count", 32'(edge_count), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
